pingpong_ctrl_2048x60: RTL and testbench
========================================

# pingpong_ctrl_2048x60

Double-buffer (ping-pong) controller that owns one `dpram_2048_60bit` instance and splits it into two 1024-word banks. A producer streams fixed-length frames into one bank through port A while a consumer drains the other bank through port B, with valid/ready handshakes on both sides. It sits between an upstream 60-bit activation/weight stream and a downstream compute stage, decoupling their rates at frame granularity.

## Interface
- `FRAME_WORDS`, 1024: words per frame, legal 1..1024.
- `AWIDTH`, 11: RAM address width, passed to the RAM.
- `DWIDTH`, 60: data width, passed to the RAM.
- `clk`  in  1  single clock; all logic on posedge.
- `resetn`  in  1  reset, asynchronous, active-low.
- `clear`  in  1  synchronous abort; drops all frames.
- `wr_valid`  in  1  producer word valid.
- `wr_ready`  out  1  controller can accept a word.
- `wr_data`  in  DWIDTH  producer word.
- `rd_valid`  out  1  output word valid.
- `rd_ready`  in  1  consumer accepts output word.
- `rd_data`  out  DWIDTH  output word.
- `rd_last`  out  1  qualifies the final word of a frame, with `rd_valid`.
- `bank_full`  out  2  per-bank "frame complete, not yet released" flags.
- `frame_done`  out  1  one-cycle pulse when the `rd_last` word is accepted.

## Operation
- Bank b occupies addresses b*1024 .. b*1024+FRAME_WORDS-1. Internal state: write bank `wb`, read bank `rb`, write count `wcnt` (10 bit), read-issue count `rcnt` (10 bit), `bank_full[1:0]`, read-in-flight flag, 2-entry output buffer with occupancy `occ` (0..2).
- Write side: `wr_ready` = !bank_full[wb] && !clear. On accept: port A writes `wr_data` to {wb, wcnt}; `wcnt`++. On accepting word FRAME_WORDS-1: bank_full[wb] <= 1, wb toggles, wcnt <= 0.
- Read side: issue a read on port B (wren_b tied 0, data_b tied 0) at {rb, rcnt} when bank_full[rb] && (occ + inflight - pop) < 2, where pop = rd_valid && rd_ready. On issue rcnt++; on issuing index FRAME_WORDS-1: bank_full[rb] <= 0, rb toggles, rcnt <= 0, and the in-flight entry is tagged last.
- RAM output is captured into the buffer only in the cycle after an issue. The buffer is FIFO-ordered; `rd_data`/`rd_last` come from the head entry; `rd_valid` = occ != 0.
- Set and clear of `bank_full` in the same cycle always target different banks (set needs !full[wb], clear needs full[rb]); both take effect.
- `clear`: highest priority; next edge sets wcnt=rcnt=0, wb=rb=0, bank_full=0, occ=0, inflight=0; the accepted write that cycle (if any) is discarded because `wr_ready` is low.
- Reset values: wr_ready=1 (after reset release, in the first cycle), rd_valid=0, rd_last=0, rd_data=0, bank_full=2'b00, frame_done=0; all counters and pointers are 0.

## Timing
- Write throughput: 1 word/cycle while the target bank is not full.
- Read latency: the last write of a frame is accepted at edge E; the first read issues at edge E+1; `rd_valid` is high after edge E+2.
- Read throughput: 1 word/cycle with `rd_ready` held high. No bubble occurs at a bank switch if the next bank is already full.
- Backpressure: with `rd_ready` low, at most 2 words are buffered and no further reads issue; data is never dropped or duplicated.
- A bank is released (`bank_full` falls) at the edge its last read issues. The producer may write that bank from the next cycle; the issued read already sampled the old data.
- Both banks full: `wr_ready`=0 until the reader releases a bank.
- `frame_done` is registered and pulses the cycle after the `rd_last` handshake.
- `resetn` low mid-frame: all state clears immediately; the partial frame is lost.

## Test plan
- Single frame, FRAME_WORDS=4: write 0x1,0x2,0x3,0x4 back-to-back with rd_ready=1 -> rd_valid high 2 cycles after the 4th accept; 1,2,3,4 out on consecutive cycles; rd_last on 4; frame_done one cycle later; bank_full goes 01 -> 00.
- Ping-pong overlap, FRAME_WORDS=1024: stream 3 frames continuously with rd_ready=1 -> no write stall after frame 1, bank_full toggles 01/10, all 3072 words out in order with no gaps between frames.
- Producer blocked: write 2 frames with rd_ready=0 -> bank_full=11, wr_ready=0, occ=2 (first two words of frame 0 buffered). Then raise rd_ready -> wr_ready returns 1 the cycle after frame 0's last read issues.
- Random backpressure: rd_ready toggles randomly at 50% over 8 frames -> output sequence equals input sequence, with rd_last every FRAME_WORDS words.
- Clear mid-read: assert clear while frame 0 is half drained and frame 1 is full -> next cycle rd_valid=0, bank_full=00, wr_ready=1. A new frame 0xA.. reads back from bank 0 correctly.
- Async reset: drop resetn mid-write, off the clock edge -> outputs reach their reset values without a clock edge; a fresh frame after release behaves as in scenario 1.

Source files
------------

// File: rtl/pingpong_ctrl_2048x60.sv
// Ping-pong frame buffer: the producer fills one 1024-word bank of a 2048x60 RAM
// while the consumer drains the other bank through a 2-entry output FIFO.

module dpram_2048_60bit #(
  parameter int AWIDTH = 11,
  parameter int DWIDTH = 60
) (
  input  logic              clk,
  input  logic              wren_a,
  input  logic [AWIDTH-1:0] address_a,
  input  logic [DWIDTH-1:0] data_a,
  input  logic              wren_b,
  input  logic [AWIDTH-1:0] address_b,
  input  logic [DWIDTH-1:0] data_b,
  output logic [DWIDTH-1:0] q_b
);
  logic [DWIDTH-1:0] mem [0:(2**AWIDTH)-1];

  // Synchronous RAM; a read sees the contents from before this edge's writes
  always_ff @(posedge clk) begin
    if (wren_a) mem[address_a] <= data_a;
    if (wren_b) mem[address_b] <= data_b;
    q_b <= mem[address_b];
  end
endmodule

module pingpong_ctrl_2048x60 #(
  parameter int FRAME_WORDS = 1024,
  parameter int AWIDTH      = 11,
  parameter int DWIDTH      = 60
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              clear,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DWIDTH-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DWIDTH-1:0] rd_data,
  output logic              rd_last,
  output logic [1:0]        bank_full,
  output logic              frame_done
);
  localparam logic [9:0] LAST_IDX = 10'(FRAME_WORDS - 1);

  logic              wb_q, wb_d, rb_q, rb_d;
  logic [9:0]        wcnt_q, wcnt_d, rcnt_q, rcnt_d;
  logic [1:0]        full_q, full_d;
  logic              infl_q, infl_d, infl_last_q, infl_last_d;
  logic [1:0]        occ_q, occ_d;
  logic [DWIDTH-1:0] buf0_q, buf0_d, buf1_q, buf1_d;
  logic              buf0_last_q, buf0_last_d, buf1_last_q, buf1_last_d;
  logic              frame_done_q, frame_done_d;

  logic              wr_accept_s, pop_s, rd_issue_s;
  logic [2:0]        level_s;
  logic [DWIDTH-1:0] ram_q_s;

  assign wr_ready    = !full_q[wb_q] && !clear;
  assign wr_accept_s = wr_valid && wr_ready;
  assign pop_s       = (occ_q != 2'd0) && rd_ready;
  // Buffer slots already claimed after this cycle's pop; an issue needs a free one
  assign level_s     = {1'b0, occ_q} + {2'b00, infl_q} - {2'b00, pop_s};
  assign rd_issue_s  = !clear && full_q[rb_q] && (level_s < 3'd2);

  assign rd_valid   = (occ_q != 2'd0);
  assign rd_data    = buf0_q;
  assign rd_last    = buf0_last_q && (occ_q != 2'd0);
  assign bank_full  = full_q;
  assign frame_done = frame_done_q;

  dpram_2048_60bit #(
    .AWIDTH (AWIDTH),
    .DWIDTH (DWIDTH)
  ) u_ram (
    .clk       (clk),
    .wren_a    (wr_accept_s),
    .address_a (AWIDTH'({wb_q, wcnt_q})),
    .data_a    (wr_data),
    .wren_b    (1'b0),
    .address_b (AWIDTH'({rb_q, rcnt_q})),
    .data_b    ({DWIDTH{1'b0}}),
    .q_b       (ram_q_s)
  );

  // Next-state for bank pointers, counters, full flags and the output FIFO
  always_comb begin
    wb_d         = wb_q;
    rb_d         = rb_q;
    wcnt_d       = wcnt_q;
    rcnt_d       = rcnt_q;
    full_d       = full_q;
    occ_d        = occ_q;
    buf0_d       = buf0_q;
    buf1_d       = buf1_q;
    buf0_last_d  = buf0_last_q;
    buf1_last_d  = buf1_last_q;
    infl_d       = rd_issue_s;
    infl_last_d  = rd_issue_s && (rcnt_q == LAST_IDX);
    frame_done_d = pop_s && buf0_last_q;
    if (clear) begin
      wb_d        = 1'b0;
      rb_d        = 1'b0;
      wcnt_d      = 10'd0;
      rcnt_d      = 10'd0;
      full_d      = 2'b00;
      occ_d       = 2'd0;
      infl_d      = 1'b0;
      infl_last_d = 1'b0;
    end else begin
      if (wr_accept_s) begin
        if (wcnt_q == LAST_IDX) begin
          full_d[wb_q] = 1'b1;
          wb_d         = ~wb_q;
          wcnt_d       = 10'd0;
        end else begin
          wcnt_d = wcnt_q + 10'd1;
        end
      end else begin
        wcnt_d = wcnt_q;
      end
      // Set and release always hit different banks, so both may apply
      if (rd_issue_s) begin
        if (rcnt_q == LAST_IDX) begin
          full_d[rb_q] = 1'b0;
          rb_d         = ~rb_q;
          rcnt_d       = 10'd0;
        end else begin
          rcnt_d = rcnt_q + 10'd1;
        end
      end else begin
        rcnt_d = rcnt_q;
      end
      occ_d = occ_q + {1'b0, infl_q} - {1'b0, pop_s};
      case ({infl_q, pop_s})
        2'b10: begin
          if (occ_q == 2'd0) begin
            buf0_d      = ram_q_s;
            buf0_last_d = infl_last_q;
          end else begin
            buf1_d      = ram_q_s;
            buf1_last_d = infl_last_q;
          end
        end
        2'b01: begin
          buf0_d      = buf1_q;
          buf0_last_d = buf1_last_q;
        end
        2'b11: begin
          if (occ_q == 2'd1) begin
            buf0_d      = ram_q_s;
            buf0_last_d = infl_last_q;
          end else begin
            buf0_d      = buf1_q;
            buf0_last_d = buf1_last_q;
            buf1_d      = ram_q_s;
            buf1_last_d = infl_last_q;
          end
        end
        default: begin
          occ_d = occ_q;
        end
      endcase
    end
  end

  // State register with asynchronous active-low reset
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wb_q         <= 1'b0;
      rb_q         <= 1'b0;
      wcnt_q       <= 10'd0;
      rcnt_q       <= 10'd0;
      full_q       <= 2'b00;
      infl_q       <= 1'b0;
      infl_last_q  <= 1'b0;
      occ_q        <= 2'd0;
      buf0_q       <= {DWIDTH{1'b0}};
      buf1_q       <= {DWIDTH{1'b0}};
      buf0_last_q  <= 1'b0;
      buf1_last_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      wb_q         <= wb_d;
      rb_q         <= rb_d;
      wcnt_q       <= wcnt_d;
      rcnt_q       <= rcnt_d;
      full_q       <= full_d;
      infl_q       <= infl_d;
      infl_last_q  <= infl_last_d;
      occ_q        <= occ_d;
      buf0_q       <= buf0_d;
      buf1_q       <= buf1_d;
      buf0_last_q  <= buf0_last_d;
      buf1_last_q  <= buf1_last_d;
      frame_done_q <= frame_done_d;
    end
  end
endmodule

// File: tb/tb_pingpong_ctrl_2048x60.sv
// Randomized bench for pingpong_ctrl_2048x60 with 4-word frames; the reference
// model is "output stream equals accepted input stream, last on every 4th word".

module tb_pingpong_ctrl_2048x60;
  localparam int FW = 4;
  localparam int DW = 60;

  logic          clk = 1'b0;
  logic          resetn = 1'b1;
  logic          clear = 1'b0;
  logic          wr_valid = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_ready = 1'b0;
  logic          wr_ready, rd_valid, rd_last, frame_done;
  logic [DW-1:0] rd_data;
  logic [1:0]    bank_full;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int fd_cnt = 0;
  logic [DW-1:0] wr_log[$];
  logic [DW:0]   rd_log[$];
  int            rd_cyc[$];

  pingpong_ctrl_2048x60 #(.FRAME_WORDS(FW), .AWIDTH(11), .DWIDTH(DW)) dut (
    .clk(clk), .resetn(resetn), .clear(clear),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .rd_last(rd_last), .bank_full(bank_full), .frame_done(frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: records handshakes mid-cycle, away from the active edge
  always @(negedge clk) begin
    if (resetn) begin
      if (wr_valid && wr_ready) wr_log.push_back(wr_data);
      if (rd_valid && rd_ready) begin
        rd_log.push_back({rd_last, rd_data});
        rd_cyc.push_back(cyc);
      end
      if (frame_done) fd_cnt++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_logs();
    wr_log.delete();
    rd_log.delete();
    rd_cyc.delete();
    fd_cnt = 0;
  endtask

  // Reference model: n-th word out is the n-th word accepted, last on frame end
  function automatic logic [DW:0] model_out(int n);
    logic lst;
    lst = ((n % FW) == FW - 1);
    return {lst, wr_log[n]};
  endfunction

  function automatic logic [DW-1:0] rnd_word();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[DW-1:0];
  endfunction

  task automatic test_reset();
    #2 resetn = 1'b0;
    step(); step();
    resetn = 1'b1;
    #1;
    checks += 6;
    if (wr_ready !== 1'b1) begin failures++; $display("FAIL reset_wr_ready got=%b exp=1", wr_ready); end
    if (rd_valid !== 1'b0) begin failures++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); end
    if (rd_last !== 1'b0) begin failures++; $display("FAIL reset_rd_last got=%b exp=0", rd_last); end
    if (rd_data !== '0) begin failures++; $display("FAIL reset_rd_data got=%h exp=0", rd_data); end
    if (bank_full !== 2'b00) begin failures++; $display("FAIL reset_bank_full got=%b exp=00", bank_full); end
    if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_frame_done got=%b exp=0", frame_done); end
  endtask

  task automatic test_single_frame();
    logic          exp_rv, exp_last, exp_fd;
    logic [1:0]    exp_bf;
    clr_logs();
    rd_ready = 1'b1;
    for (int i = 0; i < FW; i++) begin
      wr_valid = 1'b1;
      wr_data  = DW'(i + 1);
      checks++;
      if (wr_ready !== 1'b1) begin failures++; $display("FAIL single_wr_ready word=%0d got=%b exp=1", i, wr_ready); end
      step();
    end
    wr_valid = 1'b0;
    // k counts edges after the edge that accepted the last write
    for (int k = 0; k < 8; k++) begin
      exp_rv   = (k >= 2) && (k <= 5);
      exp_last = (k == 5);
      exp_fd   = (k == 6);
      exp_bf   = (k < 4) ? 2'b01 : 2'b00;
      checks += 4;
      if (rd_valid !== exp_rv) begin failures++; $display("FAIL single_rd_valid k=%0d got=%b exp=%b", k, rd_valid, exp_rv); end
      if (rd_last !== exp_last) begin failures++; $display("FAIL single_rd_last k=%0d got=%b exp=%b", k, rd_last, exp_last); end
      if (frame_done !== exp_fd) begin failures++; $display("FAIL single_frame_done k=%0d got=%b exp=%b", k, frame_done, exp_fd); end
      if (bank_full !== exp_bf) begin failures++; $display("FAIL single_bank_full k=%0d got=%b exp=%b", k, bank_full, exp_bf); end
      if (exp_rv) begin
        checks++;
        if (rd_data !== DW'(k - 1)) begin failures++; $display("FAIL single_rd_data k=%0d got=%h exp=%h", k, rd_data, DW'(k - 1)); end
      end
      step();
    end
    rd_ready = 1'b0;
    checks++;
    if (fd_cnt != 1) begin failures++; $display("FAIL single_fd_count got=%0d exp=1", fd_cnt); end
  endtask

  task automatic test_pingpong();
    int i = 0, stalls = 0, both = 0, saw01 = 0, saw10 = 0;
    clr_logs();
    rd_ready = 1'b1;
    for (int g = 0; g < 200 && i < 3 * FW; g++) begin
      wr_valid = 1'b1;
      wr_data  = rnd_word();
      if (wr_ready) i++; else stalls++;
      if (bank_full == 2'b11) both++;
      if (bank_full == 2'b01) saw01++;
      if (bank_full == 2'b10) saw10++;
      step();
    end
    wr_valid = 1'b0;
    for (int g = 0; g < 20; g++) begin
      if (bank_full == 2'b11) both++;
      if (bank_full == 2'b10) saw10++;
      step();
    end
    rd_ready = 1'b0;
    checks += 5;
    if (stalls != 0) begin failures++; $display("FAIL pingpong_stalls got=%0d exp=0", stalls); end
    if (both != 0) begin failures++; $display("FAIL pingpong_both_full got=%0d exp=0", both); end
    if (saw01 == 0 || saw10 == 0) begin failures++; $display("FAIL pingpong_toggle saw01=%0d saw10=%0d exp=nonzero", saw01, saw10); end
    if (wr_log.size() != 3 * FW) begin failures++; $display("FAIL pingpong_wr_count got=%0d exp=%0d", wr_log.size(), 3 * FW); end
    if (rd_log.size() != 3 * FW) begin failures++; $display("FAIL pingpong_rd_count got=%0d exp=%0d", rd_log.size(), 3 * FW); end
    for (int n = 0; n < rd_log.size() && n < wr_log.size(); n++) begin
      checks++;
      if (rd_log[n] !== model_out(n)) begin failures++; $display("FAIL pingpong_word n=%0d got=%h exp=%h", n, rd_log[n], model_out(n)); end
      if (n > 0) begin
        checks++;
        if (rd_cyc[n] != rd_cyc[n-1] + 1) begin failures++; $display("FAIL pingpong_gap n=%0d got=%0d exp=%0d", n, rd_cyc[n], rd_cyc[n-1] + 1); end
      end
    end
  endtask

  task automatic test_blocked();
    clr_logs();
    rd_ready = 1'b0;
    for (int g = 0; g < 2 * FW + 3; g++) begin
      wr_valid = 1'b1;
      wr_data  = rnd_word();
      step();
    end
    wr_valid = 1'b0;
    step(); step(); step();
    checks += 4;
    if (wr_log.size() != 2 * FW) begin failures++; $display("FAIL blocked_wr_count got=%0d exp=%0d", wr_log.size(), 2 * FW); end
    if (bank_full !== 2'b11) begin failures++; $display("FAIL blocked_bank_full got=%b exp=11", bank_full); end
    if (wr_ready !== 1'b0) begin failures++; $display("FAIL blocked_wr_ready got=%b exp=0", wr_ready); end
    if (rd_valid !== 1'b1) begin failures++; $display("FAIL blocked_rd_valid got=%b exp=1", rd_valid); end
    if (wr_log.size() >= 3) begin
      checks++;
      if (rd_data !== wr_log[0]) begin failures++; $display("FAIL blocked_head got=%h exp=%h", rd_data, wr_log[0]); end
      rd_ready = 1'b1;
      step();
      checks += 3;
      if (wr_ready !== 1'b0) begin failures++; $display("FAIL blocked_wr_ready_e1 got=%b exp=0", wr_ready); end
      if (rd_valid !== 1'b1) begin failures++; $display("FAIL blocked_rd_valid_e1 got=%b exp=1", rd_valid); end
      if (rd_data !== wr_log[1]) begin failures++; $display("FAIL blocked_second_buffered got=%h exp=%h", rd_data, wr_log[1]); end
      step();
      checks += 2;
      if (wr_ready !== 1'b1) begin failures++; $display("FAIL blocked_wr_ready_e2 got=%b exp=1", wr_ready); end
      if (rd_data !== wr_log[2]) begin failures++; $display("FAIL blocked_rd_data_e2 got=%h exp=%h", rd_data, wr_log[2]); end
    end
    rd_ready = 1'b1;
    for (int g = 0; g < 20; g++) step();
    rd_ready = 1'b0;
    checks++;
    if (rd_log.size() != 2 * FW) begin failures++; $display("FAIL blocked_rd_count got=%0d exp=%0d", rd_log.size(), 2 * FW); end
    for (int n = 0; n < rd_log.size() && n < wr_log.size(); n++) begin
      checks++;
      if (rd_log[n] !== model_out(n)) begin failures++; $display("FAIL blocked_word n=%0d got=%h exp=%h", n, rd_log[n], model_out(n)); end
    end
  endtask

  task automatic test_random_bp();
    int i = 0;
    logic [DW-1:0] words[$];
    clr_logs();
    for (int n = 0; n < 8 * FW; n++) words.push_back(rnd_word());
    for (int g = 0; g < 1000 && (i < 8 * FW || rd_log.size() < 8 * FW); g++) begin
      wr_valid = (i < 8 * FW) && ($urandom_range(0, 3) != 0);
      wr_data  = (i < 8 * FW) ? words[i] : '0;
      rd_ready = ($urandom_range(0, 1) == 1);
      if (wr_valid && wr_ready) i++;
      step();
    end
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    checks += 2;
    if (i != 8 * FW) begin failures++; $display("FAIL random_timeout_wr got=%0d exp=%0d", i, 8 * FW); end
    if (rd_log.size() != 8 * FW) begin failures++; $display("FAIL random_timeout_rd got=%0d exp=%0d", rd_log.size(), 8 * FW); end
    for (int n = 0; n < rd_log.size() && n < words.size(); n++) begin
      checks++;
      if (rd_log[n] !== {((n % FW) == FW - 1), words[n]}) begin
        failures++;
        $display("FAIL random_word n=%0d got=%h exp=%h", n, rd_log[n], {((n % FW) == FW - 1), words[n]});
      end
    end
  endtask

  task automatic test_clear();
    clr_logs();
    rd_ready = 1'b0;
    for (int g = 0; g < 2 * FW + 2; g++) begin
      wr_valid = 1'b1;
      wr_data  = rnd_word();
      step();
    end
    wr_valid = 1'b0;
    step(); step(); step();
    rd_ready = 1'b1;
    step(); step();
    rd_ready = 1'b0;
    clear    = 1'b1;
    wr_valid = 1'b1;
    wr_data  = 60'hBAD;
    #1;
    checks++;
    if (wr_ready !== 1'b0) begin failures++; $display("FAIL clear_wr_ready_during got=%b exp=0", wr_ready); end
    step();
    clear    = 1'b0;
    wr_valid = 1'b0;
    #1;
    checks += 4;
    if (wr_log.size() != 2 * FW) begin failures++; $display("FAIL clear_discard got=%0d exp=%0d", wr_log.size(), 2 * FW); end
    if (rd_valid !== 1'b0) begin failures++; $display("FAIL clear_rd_valid got=%b exp=0", rd_valid); end
    if (bank_full !== 2'b00) begin failures++; $display("FAIL clear_bank_full got=%b exp=00", bank_full); end
    if (wr_ready !== 1'b1) begin failures++; $display("FAIL clear_wr_ready got=%b exp=1", wr_ready); end
    clr_logs();
    step();
    rd_ready = 1'b1;
    for (int n = 0; n < FW; n++) begin
      wr_valid = 1'b1;
      wr_data  = DW'(32'hA + n);
      step();
    end
    wr_valid = 1'b0;
    for (int g = 0; g < 12; g++) step();
    rd_ready = 1'b0;
    checks++;
    if (rd_log.size() != FW) begin failures++; $display("FAIL clear_new_count got=%0d exp=%0d", rd_log.size(), FW); end
    for (int n = 0; n < rd_log.size() && n < FW; n++) begin
      checks++;
      if (rd_log[n] !== {(n == FW - 1), DW'(32'hA + n)}) begin
        failures++;
        $display("FAIL clear_new_word n=%0d got=%h exp=%h", n, rd_log[n], {(n == FW - 1), DW'(32'hA + n)});
      end
    end
  endtask

  task automatic test_async_reset();
    clr_logs();
    rd_ready = 1'b0;
    for (int g = 0; g < FW + 2; g++) begin
      wr_valid = 1'b1;
      wr_data  = rnd_word();
      step();
    end
    wr_valid = 1'b0;
    step(); step(); step();
    checks++;
    if (rd_valid !== 1'b1) begin failures++; $display("FAIL areset_pre_rd_valid got=%b exp=1", rd_valid); end
    #2 resetn = 1'b0;
    #1;
    checks += 6;
    if (rd_valid !== 1'b0) begin failures++; $display("FAIL areset_rd_valid got=%b exp=0", rd_valid); end
    if (rd_data !== '0) begin failures++; $display("FAIL areset_rd_data got=%h exp=0", rd_data); end
    if (rd_last !== 1'b0) begin failures++; $display("FAIL areset_rd_last got=%b exp=0", rd_last); end
    if (bank_full !== 2'b00) begin failures++; $display("FAIL areset_bank_full got=%b exp=00", bank_full); end
    if (wr_ready !== 1'b1) begin failures++; $display("FAIL areset_wr_ready got=%b exp=1", wr_ready); end
    if (frame_done !== 1'b0) begin failures++; $display("FAIL areset_frame_done got=%b exp=0", frame_done); end
    step(); step();
    resetn = 1'b1;
    step();
    test_single_frame();
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_pingpong();
    test_blocked();
    test_random_bp();
    test_clear();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1);
  end
endmodule
